// File: rtl/seq_mag_comp.sv
// Serial magnitude comparator: walks DIGIT-bit slices from the MSB end and
// stops on the first unequal slice. Signed mode uses offset-binary operands.
//
// state | meaning
// IDLE  | waiting for start; last result flags held
// CMP   | comparing slice idx, one slice per clock
module seq_mag_comp #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             aeb,
  output logic             agb,
  output logic             alb
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("seq_mag_comp: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ra, rb, ra_nx, rb_nx;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [DIGIT-1:0] sa, sb;
  logic [IW-1:0]    idx, idx_nx;
  logic             done_nx, aeb_nx, agb_nx, alb_nx;

  assign sh_a = ra >> (idx * DIGIT);
  assign sh_b = rb >> (idx * DIGIT);
  assign sa   = sh_a[DIGIT-1:0];
  assign sb   = sh_b[DIGIT-1:0];
  assign busy = (state == CMP);

  always_comb begin
    state_nx = state;
    ra_nx    = ra;
    rb_nx    = rb;
    idx_nx   = idx;
    done_nx  = 1'b0;
    aeb_nx   = aeb;
    agb_nx   = agb;
    alb_nx   = alb;
    case (state)
      IDLE: begin
        if (start) begin
          // Flipping both sign bits maps two's complement onto unsigned order.
          ra_nx    = signed_mode ? (a ^ MSB_MASK) : a;
          rb_nx    = signed_mode ? (b ^ MSB_MASK) : b;
          aeb_nx   = 1'b0;
          agb_nx   = 1'b0;
          alb_nx   = 1'b0;
          idx_nx   = IW'(N - 1);
          state_nx = CMP;
        end
      end
      CMP: begin
        if (sa > sb) begin
          agb_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (sa < sb) begin
          alb_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (idx == '0) begin
          aeb_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          idx_nx = idx - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      aeb   <= 1'b0;
      agb   <= 1'b0;
      alb   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      aeb   <= aeb_nx;
      agb   <= agb_nx;
      alb   <= alb_nx;
    end
  end

  always_ff @(posedge clk) begin
    ra  <= ra_nx;
    rb  <= rb_nx;
    idx <= idx_nx;
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: a 16/4 instance and an 8/8 instance, with a
// scoreboard of expected flags and latency per accepted compare.
module tb_seq_mag_comp;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic        start16, sm16, busy16, done16, aeb16, agb16, alb16;
  logic [15:0] a16, b16;
  logic        start8, sm8, busy8, done8, aeb8, agb8, alb8;
  logic [7:0]  a8, b8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    int         acc_cyc;
  } exp_t;
  exp_t sbq[$];

  seq_mag_comp #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .signed_mode(sm16), .busy(busy16), .done(done16),
    .aeb(aeb16), .agb(agb16), .alb(alb16)
  );

  seq_mag_comp #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .signed_mode(sm8), .busy(busy8), .done(done8),
    .aeb(aeb8), .agb(agb8), .alb(alb8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ref_flags(logic [15:0] av, logic [15:0] bv, int w, bit sm);
    int va, vb;
    va = int'(av) & ((1 << w) - 1);
    vb = int'(bv) & ((1 << w) - 1);
    if (sm) begin
      if (va >= (1 << (w - 1))) va = va - (1 << w);
      if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
    end
    if (va == vb) return 3'b100;
    if (va > vb)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_lat(logic [15:0] av, logic [15:0] bv, int w, int d);
    int x;
    x = int'(av ^ bv) & ((1 << w) - 1);
    for (int k = w / d - 1; k >= 0; k--)
      if (((x >> (k * d)) & ((1 << d) - 1)) != 0) return w / d - k;
    return w / d;
  endfunction

  function automatic logic [2:0] flags_of(bit sel);
    return sel ? {aeb8, agb8, alb8} : {aeb16, agb16, alb16};
  endfunction

  // Drives start for one edge; returns just after the accepting edge.
  task automatic issue(bit sel, logic [15:0] av, logic [15:0] bv, bit sm);
    exp_t e;
    e.flags   = ref_flags(av, bv, sel ? 8 : 16, sm);
    e.lat     = ref_lat(av, bv, sel ? 8 : 16, sel ? 8 : 4);
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    if (sel) begin a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; start8 = 1'b1; end
    else     begin a16 = av;     b16 = bv;     sm16 = sm; start16 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    checks++;
    if ((sel ? busy8 : busy16) !== 1'b1 || flags_of(sel) !== 3'b000 || (sel ? done8 : done16) !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b done=%b flags=%b, required busy=1 done=0 flags=000",
               sel ? busy8 : busy16, sel ? done8 : done16, flags_of(sel));
    end
  endtask

  task automatic wait_done(bit sel);
    int   n;
    exp_t e;
    n = 0;
    while ((sel ? done8 : done16) !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles, required a done pulse");
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: done seen with no pending compare");
      return;
    end
    e = sbq.pop_front();
    checks++;
    if (flags_of(sel) !== e.flags) begin
      errors++;
      $display("FAIL flags: aeb/agb/alb=%b, required %b", flags_of(sel), e.flags);
    end
    checks++;
    if (cyc - e.acc_cyc !== e.lat || (sel ? busy8 : busy16) !== 1'b0) begin
      errors++;
      $display("FAIL latency: got %0d edges busy=%b, required %0d edges busy=0",
               cyc - e.acc_cyc, sel ? busy8 : busy16, e.lat);
    end
  endtask

  task automatic check_idle_hold(bit sel, logic [2:0] fl);
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ((sel ? done8 : done16) !== 1'b0 || (sel ? busy8 : busy16) !== 1'b0 || flags_of(sel) !== fl) begin
        errors++;
        $display("FAIL hold: done=%b busy=%b flags=%b, required done=0 busy=0 flags=%b",
                 sel ? done8 : done16, sel ? busy8 : busy16, flags_of(sel), fl);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({busy16, done16, aeb16, agb16, alb16} !== 5'b0 || {busy8, done8, aeb8, agb8, alb8} !== 5'b0) begin
      errors++;
      $display("FAIL reset: dut16=%b dut8=%b, required 00000",
               {busy16, done16, aeb16, agb16, alb16}, {busy8, done8, aeb8, agb8, alb8});
    end
  endtask

  task automatic test_equal;
    issue(1'b0, 16'h1234, 16'h1234, 1'b0);
    wait_done(1'b0);
    check_idle_hold(1'b0, 3'b100);
  endtask

  task automatic test_signed_mode;
    issue(1'b0, 16'h9000, 16'h1000, 1'b0);
    wait_done(1'b0);
    check_idle_hold(1'b0, 3'b010);
    issue(1'b0, 16'h9000, 16'h1000, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 16'h8000, 16'hFFFF, 1'b1);
    wait_done(1'b0);
  endtask

  task automatic test_low_slice;
    issue(1'b0, 16'h12F4, 16'h12F5, 1'b0);
    wait_done(1'b0);
    issue(1'b0, 16'h12F5, 16'h12F4, 1'b0);
    wait_done(1'b0);
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      wait_done(1'b0);
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'h0000; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    wait_done(1'b0);
    issue(1'b0, 16'h0001, 16'h0002, 1'b0);
    wait_done(1'b0);
    check_idle_hold(1'b0, 3'b001);
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sbq.pop_front());
    checks++;
    if ({busy16, done16, aeb16, agb16, alb16} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid: busy/done/flags=%b, required 00000", {busy16, done16, aeb16, agb16, alb16});
    end
    check_idle_hold(1'b0, 3'b000);
    issue(1'b0, 16'hA5A5, 16'hA5A4, 1'b0);
    wait_done(1'b0);
  endtask

  task automatic test_single_slice;
    issue(1'b1, 16'd200, 16'd100, 1'b0);
    wait_done(1'b1);
    issue(1'b1, 16'd200, 16'd100, 1'b1);
    wait_done(1'b1);
    issue(1'b1, 16'd77, 16'd77, 1'b1);
    wait_done(1'b1);
    check_idle_hold(1'b1, 3'b100);
  endtask

  initial begin
    rst = 1'b1;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    test_reset();
    test_equal();
    test_signed_mode();
    test_low_slice();
    test_back_to_back();
    test_reset_mid();
    test_single_slice();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Parametrised multi-cycle magnitude comparator for wide operands.
- Compares a and b one DIGIT-bit slice per clock, most significant slice first, like chained 4-bit comparators resolved serially.
- Stops early on the first unequal slice and supports an unsigned or two's-complement signed mode.
- Sits beside the combinational 4-bit comparators when WIDTH makes a flat compare too slow or too large.

Parameters:
- WIDTH, 32, operand width in bits.
- DIGIT, 4, slice width compared per cycle; WIDTH % DIGIT must equal 0 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when idle.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; result valid from this cycle on.
- aeb  output  1  A equals B.
- agb  output  1  A greater than B.
- alb  output  1  A less than B.

Behaviour:
- Definitions:
  - N = WIDTH/DIGIT.
  - Slice k = bits [k*DIGIT+DIGIT-1 : k*DIGIT].
  - The index register has width $clog2(N), minimum 1.
- Reset (rst=1 at a rising edge, which overrides everything):
  - State goes to IDLE.
  - busy, done, aeb, agb and alb all go to 0.
  - Operand registers and index are don't-care.
  - Reset mid-compare abandons the compare with no done pulse.
- State IDLE:
  - busy=0.
  - If start=1, then at that edge:
    - Capture a, b and signed_mode.
    - If signed_mode=1, invert bit WIDTH-1 of both captured operands (offset-binary), so an unsigned slice compare gives the signed result.
    - Clear aeb, agb and alb to 0.
    - Set idx=N-1 and go to CMP.
  - If start=0, hold state; the last result flags hold indefinitely.
- State CMP:
  - busy=1.
  - At each edge, compare captured slice idx of A against slice idx of B, unsigned:
    - A slice > B slice: set agb=1, done=1, go to IDLE.
    - A slice < B slice: set alb=1, done=1, go to IDLE.
    - Slices equal and idx==0: set aeb=1, done=1, go to IDLE.
    - Slices equal and idx>0: idx <= idx-1, stay in CMP.
- done:
  - High for exactly one cycle after the deciding edge.
  - Cleared at the next edge unless a new decision occurs.
- Latency, counted from the edge that accepts start:
  - Done is visible after m more edges, where m is the number of slices examined (1..N).
  - Worst case (equal operands or differ only in slice 0) = N.
- Exactly one of aeb, agb, alb is 1 after any completed compare. All three are 0 from acceptance of start until done.
- start while busy=1 is ignored: no capture, no effect on the running compare. Operand inputs may change freely after acceptance.
- Back-to-back operation:
  - start=1 in the cycle done=1 is accepted, because state is already IDLE.
  - At that edge the flags clear and done drops.
- N=1 (DIGIT=WIDTH) is a legal configuration: every compare completes in 1 cycle.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=16, DIGIT=4, unsigned; rst held 2 cycles -> busy=done=aeb=agb=alb=0. Then a=16'h1234, b=16'h1234, start -> busy 4 cycles, done pulse on the 4th edge after acceptance, aeb=1, agb=alb=0, flags held afterwards.
- a=16'h9000, b=16'h1000, signed_mode=0 -> agb=1, done 1 edge after acceptance. Same operands with signed_mode=1 -> alb=1 (-28672 < 4096), same latency.
- a=16'h12F4, b=16'h12F5, unsigned -> 4-cycle compare, alb=1. Swap operands -> agb=1. a=16'h8000, b=16'hFFFF, signed -> alb=1 in 1 cycle.
- During a compare of 16'h0000 vs 16'h0000, pulse start with a=16'hFFFF, b=0 at cycle 2 -> ignored, result aeb=1 at cycle 4. Then assert start in the done cycle with a=16'h0001, b=16'h0002 -> accepted, flags clear, alb=1 after 4 cycles.
- Assert rst at cycle 2 of a 4-cycle compare -> next cycle busy=0, no done pulse, all flags 0. A following start completes normally.
- Config WIDTH=8, DIGIT=8: a=8'd200, b=8'd100 unsigned -> agb=1 and done 1 edge after acceptance. Signed -> alb=1.
